// File: rtl/imm_gen_pkg.sv
// Shared opcode and mode encodings for the registered immediate generator.
package imm_gen_pkg;

  localparam logic [2:0] OP_ADDI = 3'b011;
  localparam logic [2:0] OP_ORI  = 3'b100;
  localparam logic [2:0] OP_LUI  = 3'b101;

  typedef enum logic [1:0] {
    MODE_SIGN  = 2'd0,
    MODE_ZERO  = 2'd1,
    MODE_UPPER = 2'd2,
    MODE_DFLT  = 2'd3
  } imm_mode_e;

endpackage

// File: rtl/imm_decode.sv
// Combinational opcode decode and immediate extension.
// Unsupported opcodes fall back to sign extension and raise err_o.
module imm_decode #(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16,
  parameter int OP_W   = 3,
  parameter logic [OP_W-1:0] OP_ADDI = OP_W'(imm_gen_pkg::OP_ADDI),
  parameter logic [OP_W-1:0] OP_ORI  = OP_W'(imm_gen_pkg::OP_ORI),
  parameter logic [OP_W-1:0] OP_LUI  = OP_W'(imm_gen_pkg::OP_LUI)
) (
  input  logic [OP_W-1:0]        opcode_i,
  input  logic [IMM_W-1:0]       imm_i,
  output logic [DATA_W-1:0]      imm_o,
  output imm_gen_pkg::imm_mode_e mode_o,
  output logic                   err_o
);
  import imm_gen_pkg::*;

  logic [DATA_W-1:0] sext;
  logic [DATA_W-1:0] zext;
  logic [DATA_W-1:0] upper;

  assign sext  = DATA_W'($signed(imm_i));
  assign zext  = DATA_W'(imm_i);
  // Shift form also covers DATA_W == IMM_W.
  assign upper = zext << (DATA_W - IMM_W);

  always_comb begin
    imm_o  = sext;
    mode_o = MODE_DFLT;
    err_o  = 1'b1;
    unique case (1'b1)
      (opcode_i == OP_ADDI): begin
        imm_o  = sext;
        mode_o = MODE_SIGN;
        err_o  = 1'b0;
      end
      (opcode_i == OP_ORI): begin
        imm_o  = zext;
        mode_o = MODE_ZERO;
        err_o  = 1'b0;
      end
      (opcode_i == OP_LUI): begin
        imm_o  = upper;
        mode_o = MODE_UPPER;
        err_o  = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator: decode at push into a 2-entry
// valid/ready FIFO, with a saturating unsupported-opcode counter.
module imm_gen_pipe #(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16,
  parameter int OP_W   = 3,
  parameter logic [OP_W-1:0] OP_ADDI = OP_W'(imm_gen_pkg::OP_ADDI),
  parameter logic [OP_W-1:0] OP_ORI  = OP_W'(imm_gen_pkg::OP_ORI),
  parameter logic [OP_W-1:0] OP_LUI  = OP_W'(imm_gen_pkg::OP_LUI),
  parameter int ERR_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_opcode,
  input  logic [IMM_W-1:0]  in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_imm,
  output logic [1:0]        out_mode,
  output logic [ERR_W-1:0]  err_cnt,
  output logic              err_flag,
  input  logic              clr_err
);
  import imm_gen_pkg::*;

  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  logic [DATA_W-1:0] dec_imm;
  imm_mode_e         dec_mode;
  logic              dec_err;

  imm_decode #(
    .DATA_W  (DATA_W),
    .IMM_W   (IMM_W),
    .OP_W    (OP_W),
    .OP_ADDI (OP_ADDI),
    .OP_ORI  (OP_ORI),
    .OP_LUI  (OP_LUI)
  ) u_dec (
    .opcode_i (in_opcode),
    .imm_i    (in_imm),
    .imm_o    (dec_imm),
    .mode_o   (dec_mode),
    .err_o    (dec_err)
  );

  logic [1:0]        cnt_q, cnt_d;
  logic              head_q, head_d;
  logic [DATA_W-1:0] imm_q [2];
  logic [DATA_W-1:0] imm_d [2];
  imm_mode_e         mode_q [2];
  imm_mode_e         mode_d [2];
  logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
  logic              err_flag_q, err_flag_d;

  logic push;
  logic pop;
  logic tail;
  logic err_ev;

  assign in_ready  = (cnt_q != 2'd2);
  assign out_valid = (cnt_q != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign tail      = head_q ^ cnt_q[0];
  assign err_ev    = push & dec_err;

  // Head slot is never the write target while occupied.
  always_comb begin
    imm_d  = imm_q;
    mode_d = mode_q;
    head_d = head_q;
    cnt_d  = cnt_q + 2'(push) - 2'(pop);
    if (push) begin
      imm_d[tail]  = dec_imm;
      mode_d[tail] = dec_mode;
    end
    if (pop) begin
      head_d = ~head_q;
    end
  end

  always_comb begin
    err_cnt_d  = err_cnt_q;
    err_flag_d = err_flag_q;
    if (clr_err) begin
      err_cnt_d  = '0;
      err_flag_d = 1'b0;
    end else if (err_ev) begin
      err_flag_d = 1'b1;
      if (err_cnt_q != ERR_MAX) begin
        err_cnt_d = err_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q      <= 2'd0;
      head_q     <= 1'b0;
      imm_q[0]   <= '0;
      imm_q[1]   <= '0;
      mode_q[0]  <= MODE_SIGN;
      mode_q[1]  <= MODE_SIGN;
      err_cnt_q  <= '0;
      err_flag_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      head_q     <= head_d;
      imm_q      <= imm_d;
      mode_q     <= mode_d;
      err_cnt_q  <= err_cnt_d;
      err_flag_q <= err_flag_d;
    end
  end

  assign out_imm  = imm_q[head_q];
  assign out_mode = mode_q[head_q];
  assign err_cnt  = err_cnt_q;
  assign err_flag = err_flag_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: default build, ERR_W=2 build,
// and DATA_W=IMM_W=16 build.
module tb_imm_gen_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // default instance
  logic        m_in_valid = 0, m_in_ready, m_out_valid, m_out_ready = 0;
  logic [2:0]  m_op = 0;
  logic [15:0] m_imm = 0;
  logic [31:0] m_out_imm;
  logic [1:0]  m_mode;
  logic [7:0]  m_err_cnt;
  logic        m_err_flag, m_clr = 0;

  imm_gen_pipe u_m (
    .clk(clk), .rst_n(rst_n),
    .in_valid(m_in_valid), .in_ready(m_in_ready),
    .in_opcode(m_op), .in_imm(m_imm),
    .out_valid(m_out_valid), .out_ready(m_out_ready),
    .out_imm(m_out_imm), .out_mode(m_mode),
    .err_cnt(m_err_cnt), .err_flag(m_err_flag), .clr_err(m_clr)
  );

  // ERR_W = 2 instance
  logic        e_in_valid = 0, e_in_ready, e_out_valid;
  logic [2:0]  e_op = 0;
  logic [15:0] e_imm = 0;
  logic [31:0] e_out_imm;
  logic [1:0]  e_mode;
  logic [1:0]  e_err_cnt;
  logic        e_err_flag;

  imm_gen_pipe #(.ERR_W(2)) u_e (
    .clk(clk), .rst_n(rst_n),
    .in_valid(e_in_valid), .in_ready(e_in_ready),
    .in_opcode(e_op), .in_imm(e_imm),
    .out_valid(e_out_valid), .out_ready(1'b1),
    .out_imm(e_out_imm), .out_mode(e_mode),
    .err_cnt(e_err_cnt), .err_flag(e_err_flag), .clr_err(1'b0)
  );

  // DATA_W = IMM_W = 16 instance
  logic        n_in_valid = 0, n_in_ready, n_out_valid;
  logic [2:0]  n_op = 0;
  logic [15:0] n_imm = 0;
  logic [15:0] n_out_imm;
  logic [1:0]  n_mode;
  logic [7:0]  n_err_cnt;
  logic        n_err_flag;

  imm_gen_pipe #(.DATA_W(16), .IMM_W(16)) u_n (
    .clk(clk), .rst_n(rst_n),
    .in_valid(n_in_valid), .in_ready(n_in_ready),
    .in_opcode(n_op), .in_imm(n_imm),
    .out_valid(n_out_valid), .out_ready(1'b1),
    .out_imm(n_out_imm), .out_mode(n_mode),
    .err_cnt(n_err_cnt), .err_flag(n_err_flag), .clr_err(1'b0)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    m_in_valid = 1; m_op = 3'b011; m_imm = 16'h1234;
    step();
    step();
    m_in_valid = 0;
    rst_n = 1;
    step();
    checks++;
    if (m_out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_out_valid got %b exp 0", m_out_valid);
    end
    checks++;
    if (m_out_imm !== 32'h0) begin
      failures++; $display("FAIL reset_out_imm got %h exp 0", m_out_imm);
    end
    checks++;
    if (m_err_cnt !== 8'd0 || m_err_flag !== 1'b0) begin
      failures++; $display("FAIL reset_err got %0d/%b exp 0/0", m_err_cnt, m_err_flag);
    end
    checks++;
    if (m_in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_in_ready got %b exp 1", m_in_ready);
    end
  endtask

  task automatic test_modes();
    m_out_ready = 1;
    m_in_valid = 1; m_op = 3'b011; m_imm = 16'h8001;
    step();
    checks++;
    if (m_out_valid !== 1'b1 || m_out_imm !== 32'hFFFF8001 || m_mode !== 2'd0) begin
      failures++; $display("FAIL addi got v=%b %h m%0d exp v=1 ffff8001 m0", m_out_valid, m_out_imm, m_mode);
    end
    m_op = 3'b100; m_imm = 16'h8001;
    step();
    checks++;
    if (m_out_valid !== 1'b1 || m_out_imm !== 32'h00008001 || m_mode !== 2'd1) begin
      failures++; $display("FAIL ori got v=%b %h m%0d exp v=1 00008001 m1", m_out_valid, m_out_imm, m_mode);
    end
    m_op = 3'b101; m_imm = 16'h1234;
    step();
    checks++;
    if (m_out_valid !== 1'b1 || m_out_imm !== 32'h12340000 || m_mode !== 2'd2) begin
      failures++; $display("FAIL lui got v=%b %h m%0d exp v=1 12340000 m2", m_out_valid, m_out_imm, m_mode);
    end
    m_in_valid = 0;
    step();
    checks++;
    if (m_out_valid !== 1'b0 || m_err_cnt !== 8'd0) begin
      failures++; $display("FAIL modes_drain got v=%b err=%0d exp v=0 err=0", m_out_valid, m_err_cnt);
    end
  endtask

  task automatic test_backpressure();
    m_out_ready = 0;
    m_in_valid = 1; m_op = 3'b011; m_imm = 16'h0001;
    step();
    m_op = 3'b100; m_imm = 16'hFFFF;
    step();
    checks++;
    if (m_in_ready !== 1'b0 || m_out_imm !== 32'h00000001) begin
      failures++; $display("FAIL bp_full got rdy=%b %h exp rdy=0 00000001", m_in_ready, m_out_imm);
    end
    m_op = 3'b101; m_imm = 16'h00FF;
    step();
    checks++;
    if (m_in_ready !== 1'b0 || m_out_imm !== 32'h00000001 || m_mode !== 2'd0) begin
      failures++; $display("FAIL bp_hold got rdy=%b %h m%0d exp rdy=0 00000001 m0", m_in_ready, m_out_imm, m_mode);
    end
    m_in_valid = 0; m_out_ready = 1;
    step();
    checks++;
    if (m_out_valid !== 1'b1 || m_out_imm !== 32'h0000FFFF || m_mode !== 2'd1 || m_in_ready !== 1'b1) begin
      failures++; $display("FAIL bp_second got v=%b %h m%0d rdy=%b exp v=1 0000ffff m1 rdy=1", m_out_valid, m_out_imm, m_mode, m_in_ready);
    end
    m_in_valid = 1; m_op = 3'b101; m_imm = 16'h00FF;
    step();
    checks++;
    if (m_out_valid !== 1'b1 || m_out_imm !== 32'h00FF0000 || m_in_ready !== 1'b1) begin
      failures++; $display("FAIL push_pop got v=%b %h rdy=%b exp v=1 00ff0000 rdy=1", m_out_valid, m_out_imm, m_in_ready);
    end
    m_in_valid = 0;
    step();
    checks++;
    if (m_out_valid !== 1'b0) begin
      failures++; $display("FAIL bp_drain got v=%b exp 0", m_out_valid);
    end
  endtask

  task automatic test_errors();
    m_out_ready = 1;
    m_in_valid = 1; m_op = 3'b111; m_imm = 16'h0005;
    step();
    checks++;
    if (m_out_imm !== 32'h00000005 || m_mode !== 2'd3 || m_err_flag !== 1'b1 || m_err_cnt !== 8'd1) begin
      failures++; $display("FAIL err1 got %h m%0d f=%b c=%0d exp 00000005 m3 f=1 c=1", m_out_imm, m_mode, m_err_flag, m_err_cnt);
    end
    m_op = 3'b000; m_imm = 16'h8000;
    step();
    checks++;
    if (m_out_imm !== 32'hFFFF8000 || m_mode !== 2'd3 || m_err_cnt !== 8'd2) begin
      failures++; $display("FAIL err2 got %h m%0d c=%0d exp ffff8000 m3 c=2", m_out_imm, m_mode, m_err_cnt);
    end
    m_in_valid = 0;
    step();
    e_in_valid = 1; e_op = 3'b110; e_imm = 16'h0003;
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (e_err_cnt !== 2'd3 || e_err_flag !== 1'b1) begin
      failures++; $display("FAIL sat3 got c=%0d f=%b exp c=3 f=1", e_err_cnt, e_err_flag);
    end
    for (int i = 0; i < 2; i++) step();
    checks++;
    if (e_err_cnt !== 2'd3) begin
      failures++; $display("FAIL sat5 got c=%0d exp 3", e_err_cnt);
    end
    e_in_valid = 0;
    step();
  endtask

  task automatic test_clear();
    m_out_ready = 1;
    m_in_valid = 1; m_op = 3'b110; m_imm = 16'h0007; m_clr = 1;
    step();
    checks++;
    if (m_err_cnt !== 8'd0 || m_err_flag !== 1'b0) begin
      failures++; $display("FAIL clr_prio got c=%0d f=%b exp c=0 f=0", m_err_cnt, m_err_flag);
    end
    checks++;
    if (m_out_valid !== 1'b1 || m_out_imm !== 32'h00000007 || m_mode !== 2'd3) begin
      failures++; $display("FAIL clr_entry got v=%b %h m%0d exp v=1 00000007 m3", m_out_valid, m_out_imm, m_mode);
    end
    m_in_valid = 0; m_clr = 0;
    step();
    checks++;
    if (m_err_cnt !== 8'd0 || m_err_flag !== 1'b0) begin
      failures++; $display("FAIL clr_after got c=%0d f=%b exp c=0 f=0", m_err_cnt, m_err_flag);
    end
  endtask

  task automatic test_mid_reset();
    m_out_ready = 0;
    m_in_valid = 1; m_op = 3'b011; m_imm = 16'h4444;
    step();
    m_imm = 16'h5555;
    step();
    checks++;
    if (m_in_ready !== 1'b0 || m_out_valid !== 1'b1) begin
      failures++; $display("FAIL mr_full got rdy=%b v=%b exp rdy=0 v=1", m_in_ready, m_out_valid);
    end
    m_in_valid = 0;
    rst_n = 0;
    step();
    rst_n = 1;
    checks++;
    if (m_out_valid !== 1'b0 || m_in_ready !== 1'b1 || m_out_imm !== 32'h0) begin
      failures++; $display("FAIL mr_reset got v=%b rdy=%b %h exp v=0 rdy=1 0", m_out_valid, m_in_ready, m_out_imm);
    end
    m_out_ready = 1;
    step();
    checks++;
    if (m_out_valid !== 1'b0) begin
      failures++; $display("FAIL mr_lost got v=%b exp 0", m_out_valid);
    end
  endtask

  task automatic test_narrow();
    n_in_valid = 1; n_op = 3'b101; n_imm = 16'hABCD;
    step();
    checks++;
    if (n_out_valid !== 1'b1 || n_out_imm !== 16'hABCD || n_mode !== 2'd2) begin
      failures++; $display("FAIL narrow_lui got v=%b %h m%0d exp v=1 abcd m2", n_out_valid, n_out_imm, n_mode);
    end
    n_op = 3'b011; n_imm = 16'h8001;
    step();
    checks++;
    if (n_out_imm !== 16'h8001 || n_mode !== 2'd0 || n_err_cnt !== 8'd0) begin
      failures++; $display("FAIL narrow_addi got %h m%0d c=%0d exp 8001 m0 c=0", n_out_imm, n_mode, n_err_cnt);
    end
    n_in_valid = 0;
    step();
  endtask

  initial begin
    test_reset();
    test_modes();
    test_backpressure();
    test_errors();
    test_clear();
    test_mid_reset();
    test_narrow();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
